// File: rtl/enc_four_two_debounced.sv
// enc_four_two_debounced
//
// Sequential 4:2 priority encoder with input debouncing and a valid/ready
// output handshake. It is the inverse of the team's 2:4 decoder:
// in_one -> 00, in_two -> 01, in_three -> 10, in_four -> 11 ({x,y}).
// When several lines are active, the highest-indexed line wins.
//
// The four request lines are registered once, giving the sample s. A nonzero
// sample must then hold unchanged for DEBOUNCE_CYCLES consecutive cycles
// before its code is reported. Each press produces exactly one code: after
// the transfer, every line must go low before the next press is accepted.
//
// Optional feature (macro ENC_MULTI_HOT_ERR_EN):
//   defined   - err is set together with valid when the reported pattern had
//               more than one active line, and is cleared on transfer.
//   undefined - err is tied to 0 and no multi-hot detection logic is built.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a nonzero pattern must stay stable (1..255)
//
// Ports:
//   clk       system clock; all logic changes on the rising edge
//   rst       synchronous, active-high reset
//   enable    1 = accept new presses; 0 = abort a debounce in progress
//   in_one    request line 0
//   in_two    request line 1
//   in_three  request line 2
//   in_four   request line 3
//   ready     consumer accepts the code when ready && valid
//   x         encoded MSB
//   y         encoded LSB
//   valid     the code on x/y is valid
//   err       the reported pattern was multi-hot (feature macro only)

module enc_four_two_debounced #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in_one,
    input  logic in_two,
    input  logic in_three,
    input  logic in_four,
    input  logic ready,
    output logic x,
    output logic y,
    output logic valid,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE,
        STABLE,
        VALID,
        RELEASE
    } state_t;

    // The count stops at this value, so an 8-bit counter never wraps.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] s;
    logic [3:0] snap;
    logic [3:0] snap_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       x_next;
    logic       y_next;
    logic       valid_next;
    logic       load_code;

    // The highest-indexed active line wins.
    function automatic logic [1:0] prio(input logic [3:0] v);
        logic [1:0] code;
        if (v[3]) begin
            code = 2'b11;
        end else if (v[2]) begin
            code = 2'b10;
        end else if (v[1]) begin
            code = 2'b01;
        end else begin
            code = 2'b00;
        end
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= 4'b0000;
            snap  <= 4'b0000;
            cnt   <= 8'd0;
            x     <= 1'b0;
            y     <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            s     <= {in_four, in_three, in_two, in_one};
            snap  <= snap_next;
            cnt   <= cnt_next;
            x     <= x_next;
            y     <= y_next;
            valid <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        snap_next  = snap;
        cnt_next   = cnt;
        x_next     = x;
        y_next     = y;
        valid_next = valid;
        load_code  = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable && (s != 4'b0000)) begin
                    snap_next  = s;
                    cnt_next   = 8'd0;
                    state_next = STABLE;
                end
            end

            STABLE: begin
                // A changed pattern or a dropped enable counts as a glitch.
                if (!enable || (s != snap)) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    {x_next, y_next} = prio(snap);
                    valid_next       = 1'b1;
                    load_code        = 1'b1;
                    state_next       = VALID;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            VALID: begin
                // x/y keep the last code after transfer; only valid drops.
                if (ready) begin
                    valid_next = 1'b0;
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                // A held line must be released before it can report again.
                if (s == 4'b0000) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ENC_MULTI_HOT_ERR_EN
    logic err_next;

    // err is set with valid and cleared with it on transfer. A pattern is
    // multi-hot exactly when clearing its lowest set bit leaves bits set.
    always_comb begin
        err_next = err;
        if (load_code) begin
            err_next = ((snap & (snap - 4'd1)) != 4'b0000);
        end else if ((state == VALID) && ready) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enc_four_two_debounced.sv
// tb_enc_four_two_debounced
//
// Directed bench for enc_four_two_debounced with the default debounce length.
// A behavioural model describes the encoder as a run-length tracker over the
// sampled request lines. A compare process checks valid/x/y/err against this
// model on every falling edge. Hand-computed literal checks pin the model at
// the key points of each scenario.

module tb_enc_four_two_debounced;

    localparam int DEB = 4;

`ifdef ENC_MULTI_HOT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic inOne = 1'b0;
    logic inTwo = 1'b0;
    logic inThree = 1'b0;
    logic inFour = 1'b0;
    logic ready = 1'b0;
    logic x;
    logic y;
    logic valid;
    logic err;

    int checks = 0;
    int failures = 0;

    enc_four_two_debounced #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in_one  (inOne),
        .in_two  (inTwo),
        .in_three(inThree),
        .in_four (inFour),
        .ready   (ready),
        .x       (x),
        .y       (y),
        .valid   (valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Model state: the last sampled pattern, the candidate pattern being
    // timed, how many consecutive qualifying edges it has survived, and
    // whether a code is waiting for transfer or waiting for release.
    bit       modelArmed = 1'b0;
    bit [3:0] mSample = 4'b0;
    bit [3:0] mCand = 4'b0;
    int       mRun = 0;
    bit       mHolding = 1'b0;
    bit       mReleasing = 1'b0;
    bit       mValid = 1'b0;
    bit [1:0] mCode = 2'b0;
    bit       mErr = 1'b0;

    function automatic bit [1:0] highestLine(input bit [3:0] v);
        bit [1:0] code = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) code = 2'(i);
        end
        return code;
    endfunction

    function automatic int activeLines(input bit [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            modelArmed = 1'b1;
            mSample    = 4'b0;
            mRun       = 0;
            mHolding   = 1'b0;
            mReleasing = 1'b0;
            mValid     = 1'b0;
            mCode      = 2'b0;
            mErr       = 1'b0;
        end else begin
            if (mHolding) begin
                if (ready) begin
                    mValid     = 1'b0;
                    mErr       = 1'b0;
                    mHolding   = 1'b0;
                    mReleasing = 1'b1;
                end
            end else if (mReleasing) begin
                if (mSample == 4'b0) mReleasing = 1'b0;
            end else if (mRun == 0) begin
                if (enable && mSample != 4'b0) begin
                    mCand = mSample;
                    mRun  = 1;
                end
            end else if (!enable || mSample != mCand) begin
                mRun = 0;
            end else if (mRun == DEB) begin
                mValid   = 1'b1;
                mCode    = highestLine(mCand);
                mErr     = ERR_EN && (activeLines(mCand) > 1);
                mHolding = 1'b1;
                mRun     = 0;
            end else begin
                mRun++;
            end
            mSample = {inFour, inThree, inTwo, inOne};
        end
    end

    always @(negedge clk) begin
        if (modelArmed) begin
            checks++;
            if (valid !== mValid || {x, y} !== mCode || err !== mErr) begin
                failures++;
                $display("[TB] FAIL model_compare t=%0t got valid=%b xy=%b%b err=%b required valid=%b xy=%b err=%b",
                         $time, valid, x, y, err, mValid, mCode, mErr);
            end
        end
    end

    // Sets all inputs just after a falling edge and lets the given number of
    // cycles run, so that each call ends on a falling edge.
    task automatic applyStimulus(input bit rstV, input bit enV, input bit [3:0] lines,
                                 input bit rdyV, input int cycles);
        rst     = rstV;
        enable  = enV;
        inOne   = lines[0];
        inTwo   = lines[1];
        inThree = lines[2];
        inFour  = lines[3];
        ready   = rdyV;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit expValid, input bit [1:0] expCode,
                               input bit expErr);
        checks++;
        if (valid !== expValid || {x, y} !== expCode || err !== expErr) begin
            failures++;
            $display("[TB] FAIL %s got valid=%b xy=%b%b err=%b required valid=%b xy=%b err=%b",
                     name, valid, x, y, err, expValid, expCode, expErr);
        end
    endtask

    initial begin
        @(negedge clk);

        // Reset
        applyStimulus(1, 0, 4'b0000, 0, 2);
        checkOutput("reset_state", 0, 2'b00, 0);

        // in_three held with ready high: valid appears after edge 6 for one cycle
        applyStimulus(0, 1, 4'b0100, 1, 5);
        checkOutput("three_edge5_not_yet", 0, 2'b00, 0);
        applyStimulus(0, 1, 4'b0100, 1, 1);
        checkOutput("three_edge6_valid", 1, 2'b10, 0);
        applyStimulus(0, 1, 4'b0100, 1, 1);
        checkOutput("three_one_cycle_pulse", 0, 2'b10, 0);
        applyStimulus(0, 1, 4'b0100, 1, 4);
        checkOutput("three_held_no_repeat", 0, 2'b10, 0);
        applyStimulus(0, 1, 4'b0000, 1, 3);

        // Short in_two glitch is rejected
        applyStimulus(0, 1, 4'b0010, 1, 2);
        applyStimulus(0, 1, 4'b0000, 1, 8);
        checkOutput("two_glitch_rejected", 0, 2'b10, 0);

        // in_two and in_four together: in_four wins, err depends on the macro
        applyStimulus(0, 1, 4'b1010, 1, 6);
        checkOutput("multi_hot_code", 1, 2'b11, ERR_EN);
        applyStimulus(0, 1, 4'b1010, 1, 1);
        checkOutput("multi_hot_err_cleared", 0, 2'b11, 0);
        applyStimulus(0, 1, 4'b0000, 1, 3);

        // in_one with ready held low: valid stays until the transfer
        applyStimulus(0, 1, 4'b0001, 0, 6);
        checkOutput("one_valid", 1, 2'b00, 0);
        applyStimulus(0, 1, 4'b0001, 0, 5);
        checkOutput("one_valid_held", 1, 2'b00, 0);
        applyStimulus(0, 1, 4'b0001, 1, 1);
        checkOutput("one_transferred", 0, 2'b00, 0);
        applyStimulus(0, 1, 4'b0001, 1, 10);
        checkOutput("one_held_no_second", 0, 2'b00, 0);
        applyStimulus(0, 1, 4'b0000, 1, 2);
        applyStimulus(0, 1, 4'b0001, 1, 6);
        checkOutput("one_repress_valid", 1, 2'b00, 0);
        applyStimulus(0, 1, 4'b0000, 1, 3);

        // A pattern change mid-debounce restarts timing on the new pattern
        applyStimulus(0, 1, 4'b0010, 1, 3);
        applyStimulus(0, 1, 4'b0100, 1, 8);
        applyStimulus(0, 1, 4'b0000, 1, 3);

        // enable low blocks presses; dropping enable mid-debounce aborts
        applyStimulus(0, 0, 4'b1000, 1, 10);
        checkOutput("disabled_no_valid", 0, 2'b10, 0);
        applyStimulus(0, 1, 4'b1000, 1, 3);
        applyStimulus(0, 0, 4'b1000, 1, 5);
        checkOutput("enable_abort", 0, 2'b10, 0);
        applyStimulus(0, 1, 4'b0000, 1, 3);

        // Two low lines: in_two wins over in_one
        applyStimulus(0, 1, 4'b0011, 0, 6);
        checkOutput("low_pair_code", 1, 2'b01, ERR_EN);

        // Reset during a pending code
        applyStimulus(1, 1, 4'b0011, 0, 1);
        checkOutput("reset_mid_valid", 0, 2'b00, 0);
        applyStimulus(0, 1, 4'b0000, 1, 6);
        checkOutput("idle_after_reset", 0, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
